// File: rtl/pps_ascii_reporter.sv
// Latches the seconds count on each PPS strobe and converts it to decimal ASCII with an iterative double-dabble.
// It then streams the digits and a line terminator to the UART. Define PPS_ZERO_SUPPRESS_EN to drop leading zeros.
`timescale 1ns/1ps
module pps_ascii_reporter #(
    parameter int TERM_CRLF = 1
) (
    input  logic        clk_50m,
    input  logic        reset_n,
    input  logic        pps,
    input  logic [15:0] second,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    localparam logic [2:0] LAST_IDX = (TERM_CRLF != 0) ? 3'd6 : 3'd5;

    state_t      state, state_nxt;
    logic [15:0] shift_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;
    logic [35:0] dd_next;
    logic [3:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic [2:0]  start_idx;
    logic        transfer;
    logic        last_byte;

    function automatic logic [7:0] byte_at(input logic [2:0] idx, input logic [19:0] bcd);
        case (idx)
            3'd0:    return {4'h3, bcd[19:16]};
            3'd1:    return {4'h3, bcd[15:12]};
            3'd2:    return {4'h3, bcd[11:8]};
            3'd3:    return {4'h3, bcd[7:4]};
            3'd4:    return {4'h3, bcd[3:0]};
            3'd5:    return (TERM_CRLF != 0) ? 8'h0D : 8'h0A;
            default: return 8'h0A;
        endcase
    endfunction

    assign busy      = (state != IDLE);
    assign transfer  = tx_valid & tx_ready;
    assign last_byte = (byte_idx == LAST_IDX);

    // Add-3 correction on every nibble, then one left shift of the combined register.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        dd_next = {bcd_adj, shift_q} << 1;
    end

`ifdef PPS_ZERO_SUPPRESS_EN
    // The units digit is always sent, so a value of 0 still prints a single '0'.
    always_comb begin
        if      (bcd_q[19:16] != 4'd0) start_idx = 3'd0;
        else if (bcd_q[15:12] != 4'd0) start_idx = 3'd1;
        else if (bcd_q[11:8]  != 4'd0) start_idx = 3'd2;
        else if (bcd_q[7:4]   != 4'd0) start_idx = 3'd3;
        else                           start_idx = 3'd4;
    end
`else
    assign start_idx = 3'd0;
`endif

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pps) state_nxt = CONV;
            CONV:    if (bit_cnt == 4'd15) state_nxt = SEND;
            SEND:    if (transfer && last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every clocked register uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // Any strobe outside IDLE, including the LF transfer cycle, is dropped.
            overrun <= pps && busy;
            if (pps && busy && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (pps) begin
                        shift_q <= second;
                        bcd_q   <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    bcd_q   <= dd_next[35:16];
                    shift_q <= dd_next[15:0];
                    bit_cnt <= bit_cnt + 4'd1;
                end
                SEND: begin
                    // The first SEND cycle loads the opening byte; later bytes load only on a transfer.
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        byte_idx <= start_idx;
                        tx_data  <= byte_at(start_idx, bcd_q);
                    end else if (transfer) begin
                        if (last_byte) begin
                            tx_valid <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= byte_at(byte_idx + 3'd1, bcd_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
